// File: rtl/stopwatch_core_if.sv
// Control pulses and display/status outputs of the stopwatch core.
interface stopwatch_core_if;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic [6:0] digit0_segments;
  logic [6:0] digit1_segments;
  logic [6:0] digit2_segments;
  logic [6:0] digit3_segments;
  logic       running;
  logic       lap_active;

  modport master (
    output start_stop, lap, clear,
    input  digit0_segments, digit1_segments, digit2_segments, digit3_segments,
    input  running, lap_active
  );

  modport slave (
    input  start_stop, lap, clear,
    output digit0_segments, digit1_segments, digit2_segments, digit3_segments,
    output running, lap_active
  );
endinterface

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch: run/pause/lap-hold FSM, BCD time counter, registered 7-segment outputs.
module stopwatch_core #(
  parameter int unsigned TICKS_PER_SEC = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_core_if.slave  sw
);

  localparam int unsigned   PW      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP_HOLD} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   time_q, time_d;   // {min tens, min units, sec tens, sec units}
  logic [15:0]   hold_q, hold_d;
  logic [27:0]   seg_q, seg_d;     // {digit3, digit2, digit1, digit0}
  logic [15:0]   disp;
  logic          counting;
  logic          tick;

  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd9) begin
      r[3:0] = t[3:0] + 4'd1;
    end else begin
      r[3:0] = '0;
      if (t[7:4] != 4'd5) begin
        r[7:4] = t[7:4] + 4'd1;
      end else begin
        r[7:4] = '0;
        if (t[11:8] != 4'd9) begin
          r[11:8] = t[11:8] + 4'd1;
        end else begin
          r[11:8]  = '0;
          r[15:12] = (t[15:12] == 4'd5) ? '0 : t[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    time_d   = time_q;
    hold_d   = hold_q;
    counting = (state_q == RUN) || (state_q == LAP_HOLD);
    tick     = counting && (pre_q == PS_LAST);

    if (counting) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end
    if (tick) begin
      time_d = bcd_inc(time_q);
    end

    // Only the highest-priority pulse is considered; a clear in RUN swallows start_stop.
    if (sw.clear) begin
      if (state_q == IDLE || state_q == PAUSE) begin
        state_d = IDLE;
        time_d  = '0;
        hold_d  = '0;
        pre_d   = '0;
      end
    end else if (sw.start_stop) begin
      case (state_q)
        IDLE:     state_d = RUN;
        RUN:      state_d = PAUSE;
        PAUSE:    state_d = RUN;
        LAP_HOLD: state_d = PAUSE;
        default:  state_d = IDLE;
      endcase
    end else if (sw.lap) begin
      if (state_q == RUN) begin
        state_d = LAP_HOLD;
        hold_d  = time_q;
      end else if (state_q == LAP_HOLD) begin
        state_d = RUN;
      end
    end

    disp  = (state_q == LAP_HOLD) ? hold_q : time_q;
    seg_d = {seg7(disp[15:12]), seg7(disp[11:8]), seg7(disp[7:4]), seg7(disp[3:0])};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      time_q  <= '0;
      hold_q  <= '0;
      seg_q   <= {4{7'h3F}};
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      time_q  <= time_d;
      hold_q  <= hold_d;
      seg_q   <= seg_d;
    end
  end

  assign sw.digit0_segments = seg_q[6:0];
  assign sw.digit1_segments = seg_q[13:7];
  assign sw.digit2_segments = seg_q[20:14];
  assign sw.digit3_segments = seg_q[27:21];
  assign sw.running         = (state_q == RUN) || (state_q == LAP_HOLD);
  assign sw.lap_active      = (state_q == LAP_HOLD);

endmodule
